rv32i_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath. It fetches one instruction word per handshake, decodes it, and drives the ALU's 4-bit operation code and operand selects. It consumes the ALU `less`/`zero` flags to resolve branches, and sequences memory access, register write-back and PC update. It is the initiator to the ALU: every `aluctr` value the ALU accepts is produced here, and only here.

---
 rtl/rv32i_mc_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctrl.sv
// rtl/rv32i_mc_ctrl.sv - multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// Optional CTRL_ILLEGAL_TRAP_EN: undecodable instructions park in TRAP with a sticky illegal flag.
module rv32i_mc_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        alu_less,
    input  logic        alu_zero,
    input  logic        mem_done,
    output logic [3:0]  aluctr,
    output logic        alu_asrc,
    output logic [1:0]  alu_bsrc,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        mem_re,
    output logic        mem_we,
    output logic [2:0]  memop,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_zero;
    logic        f7_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);
    assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b   = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u   = {instr_q[31:12], 12'd0};
    assign imm_j   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    logic [3:0]  d_aluctr;
    logic        d_asrc;
    logic [1:0]  d_bsrc;
    logic [31:0] d_imm;
    logic [1:0]  d_wb_sel;
    logic        d_legal;
    logic        d_load;
    logic        d_store;
    logic        d_branch;
    logic        d_jal;
    logic        d_jalr;
    logic        d_writes;

    // instr_q is stable from DECODE until the next fetch, so these decodes also steer EXEC/MEM/WB
    always_comb begin
        d_aluctr = ALU_ADD;
        d_asrc   = 1'b0;
        d_bsrc   = 2'b00;
        d_imm    = 32'd0;
        d_wb_sel = 2'b00;
        d_legal  = 1'b1;
        d_load   = 1'b0;
        d_store  = 1'b0;
        d_branch = 1'b0;
        d_jal    = 1'b0;
        d_jalr   = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin d_aluctr = funct7[5] ? ALU_SUB : ALU_ADD; d_legal = f7_zero | f7_alt; end
                    3'b001: begin d_aluctr = ALU_SLL;  d_legal = f7_zero; end
                    3'b010: begin d_aluctr = ALU_SLT;  d_legal = f7_zero; end
                    3'b011: begin d_aluctr = ALU_SLTU; d_legal = f7_zero; end
                    3'b100: begin d_aluctr = ALU_XOR;  d_legal = f7_zero; end
                    3'b101: begin d_aluctr = funct7[5] ? ALU_SRA : ALU_SRL; d_legal = f7_zero | f7_alt; end
                    3'b110: begin d_aluctr = ALU_OR;   d_legal = f7_zero; end
                    default: begin d_aluctr = ALU_AND; d_legal = f7_zero; end
                endcase
            end
            OP_IMM: begin
                d_bsrc = 2'b01;
                d_imm  = imm_i;
                case (funct3)
                    3'b000: d_aluctr = ALU_ADD;
                    3'b001: begin d_aluctr = ALU_SLL; d_legal = f7_zero; end
                    3'b010: d_aluctr = ALU_SLT;
                    3'b011: d_aluctr = ALU_SLTU;
                    3'b100: d_aluctr = ALU_XOR;
                    3'b101: begin d_aluctr = funct7[5] ? ALU_SRA : ALU_SRL; d_legal = f7_zero | f7_alt; end
                    3'b110: d_aluctr = ALU_OR;
                    default: d_aluctr = ALU_AND;
                endcase
            end
            OP_LUI: begin
                d_aluctr = ALU_LUI;
                d_bsrc   = 2'b01;
                d_imm    = imm_u;
            end
            OP_AUIPC: begin
                d_asrc = 1'b1;
                d_bsrc = 2'b01;
                d_imm  = imm_u;
            end
            OP_JAL: begin
                d_asrc   = 1'b1;
                d_bsrc   = 2'b10;
                d_imm    = imm_j;
                d_wb_sel = 2'b10;
                d_jal    = 1'b1;
            end
            OP_JALR: begin
                d_bsrc   = 2'b01;
                d_imm    = imm_i;
                d_wb_sel = 2'b10;
                d_jalr   = 1'b1;
                d_legal  = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                d_aluctr = funct3[1] ? ALU_SLTU : ALU_SLT;
                d_imm    = imm_b;
                d_branch = 1'b1;
                d_legal  = (funct3[2:1] != 2'b01);
            end
            OP_LOAD: begin
                d_bsrc   = 2'b01;
                d_imm    = imm_i;
                d_wb_sel = 2'b01;
                d_load   = 1'b1;
                d_legal  = !((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
            end
            OP_STORE: begin
                d_bsrc  = 2'b01;
                d_imm   = imm_s;
                d_store = 1'b1;
                d_legal = !funct3[2] && (funct3[1:0] != 2'b11);
            end
            default: d_legal = 1'b0;
        endcase
        if (!d_legal) begin
            d_aluctr = ALU_ADD;
            d_asrc   = 1'b0;
            d_bsrc   = 2'b00;
            d_imm    = 32'd0;
            d_wb_sel = 2'b00;
            d_load   = 1'b0;
            d_store  = 1'b0;
            d_branch = 1'b0;
            d_jal    = 1'b0;
            d_jalr   = 1'b0;
        end
    end

    assign d_writes = d_legal && !d_branch && !d_store;

    logic br_taken;

    always_comb begin
        case (funct3)
            3'b000:         br_taken = alu_zero;
            3'b001:         br_taken = !alu_zero;
            3'b100, 3'b110: br_taken = alu_less;
            3'b101, 3'b111: br_taken = !alu_less;
            default:        br_taken = 1'b0;
        endcase
    end

    logic       reg_we_n;
    logic       pc_we_n;
    logic [1:0] pc_src_n;
    logic       mem_re_n;
    logic       mem_we_n;
    logic       fire;

    assign fire = (state == FETCH) && instr_valid && instr_ready;

    // Strobes for a state are registered on its exit edge, so they appear one cycle later
    always_comb begin
        state_next = state;
        reg_we_n   = 1'b0;
        pc_we_n    = 1'b0;
        pc_src_n   = pc_src;
        mem_re_n   = 1'b0;
        mem_we_n   = 1'b0;
        case (state)
            FETCH: begin
                if (fire) state_next = DECODE;
            end
            DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = d_legal ? EXEC : TRAP;
`else
                state_next = EXEC;
`endif
            end
            EXEC: begin
                if (d_branch) begin
                    pc_we_n    = 1'b1;
                    pc_src_n   = br_taken ? 2'b01 : 2'b00;
                    state_next = FETCH;
                end else if (d_load || d_store) begin
                    mem_re_n   = d_load;
                    mem_we_n   = d_store;
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (mem_done) begin
                    if (d_load) begin
                        state_next = WB;
                    end else begin
                        pc_we_n    = 1'b1;
                        pc_src_n   = 2'b00;
                        state_next = FETCH;
                    end
                end else begin
                    mem_re_n = d_load;
                    mem_we_n = d_store;
                end
            end
            WB: begin
                reg_we_n   = d_writes && (rd != 5'd0);
                pc_we_n    = 1'b1;
                pc_src_n   = d_jal ? 2'b01 : (d_jalr ? 2'b10 : 2'b00);
                state_next = FETCH;
            end
            TRAP: state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= state_t'(RESET_STATE);
            instr_q     <= 32'd0;
            instr_ready <= 1'b0;
            aluctr      <= 4'd0;
            alu_asrc    <= 1'b0;
            alu_bsrc    <= 2'b00;
            imm         <= 32'd0;
            rs1         <= 5'd0;
            rs2         <= 5'd0;
            rd          <= 5'd0;
            reg_we      <= 1'b0;
            wb_sel      <= 2'b00;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            memop       <= 3'd0;
            pc_we       <= 1'b0;
            pc_src      <= 2'b00;
        end else begin
            state       <= state_next;
            instr_ready <= (state_next == FETCH);
            reg_we      <= reg_we_n;
            pc_we       <= pc_we_n;
            pc_src      <= pc_src_n;
            mem_re      <= mem_re_n;
            mem_we      <= mem_we_n;
            if (fire) instr_q <= instr_i;
            if (state == DECODE) begin
                aluctr   <= d_aluctr;
                alu_asrc <= d_asrc;
                alu_bsrc <= d_bsrc;
                imm      <= d_imm;
                rs1      <= instr_q[19:15];
                rs2      <= instr_q[24:20];
                rd       <= instr_q[11:7];
                wb_sel   <= d_wb_sel;
                memop    <= funct3;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if ((state == DECODE) && !d_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb/tb_rv32i_mc_ctrl.sv - table-driven bench for rv32i_mc_ctrl plus multi-cycle corner sequences
module tb_rv32i_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        alu_less = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_done = 1'b0;
    logic [3:0]  aluctr;
    logic        alu_asrc;
    logic [1:0]  alu_bsrc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  memop;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        illegal;

    always #5 clk = ~clk;

    rv32i_mc_ctrl dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_less(alu_less), .alu_zero(alu_zero),
        .mem_done(mem_done), .aluctr(aluctr), .alu_asrc(alu_asrc), .alu_bsrc(alu_bsrc),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_we(reg_we), .wb_sel(wb_sel),
        .mem_re(mem_re), .mem_we(mem_we), .memop(memop), .pc_we(pc_we),
        .pc_src(pc_src), .illegal(illegal)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        less;
        int          done_at;
        logic [3:0]  aluctr;
        logic        asrc;
        logic [1:0]  bsrc;
        logic        chk_sel;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  rd;
        logic [2:0]  memop;
        int          reg_we_at;
        int          pc_we_at;
        logic [1:0]  pc_src;
        logic [1:0]  wb_sel;
        int          ready_at;
        int          mem_cycles;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] w, output bit ok);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = instr_ready;
        instr_i = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx, input bit stray);
        int reg_at, pc_at, rdy_at, reg_cnt, pc_cnt, mem_cnt;
        logic [1:0] src_seen, wb_seen;
        bit ok;
        string tag;
        reg_at = -1; pc_at = -1; rdy_at = -1;
        reg_cnt = 0; pc_cnt = 0; mem_cnt = 0;
        src_seen = 2'b00; wb_seen = 2'b00;
        tag = stray ? $sformatf("stray%0d", idx) : $sformatf("v%0d", idx);
        alu_zero = v.zero;
        alu_less = v.less;
        fetch(v.instr, ok);
        chk($sformatf("%s fetch_ready", tag), {31'd0, ok}, 32'd1);
        if (stray) begin
            instr_valid = 1'b1;
            mem_done = 1'b1;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk($sformatf("%s aluctr", tag), {28'd0, aluctr}, {28'd0, v.aluctr});
                chk($sformatf("%s rd", tag), {27'd0, rd}, {27'd0, v.rd});
                if (v.chk_sel) begin
                    chk($sformatf("%s asrc", tag), {31'd0, alu_asrc}, {31'd0, v.asrc});
                    chk($sformatf("%s bsrc", tag), {30'd0, alu_bsrc}, {30'd0, v.bsrc});
                end
                if (v.chk_imm) chk($sformatf("%s imm", tag), imm, v.imm);
                if (v.mem_cycles > 0) chk($sformatf("%s memop", tag), {29'd0, memop}, {29'd0, v.memop});
            end
            if (reg_we) begin
                reg_cnt++;
                if (reg_at < 0) begin reg_at = c; wb_seen = wb_sel; end
            end
            if (pc_we) begin
                pc_cnt++;
                if (pc_at < 0) begin pc_at = c; src_seen = pc_src; end
            end
            if (instr_ready && rdy_at < 0) rdy_at = c;
            if (mem_re || mem_we) mem_cnt++;
            mem_done = (c == v.done_at) || (stray && c < 2);
            instr_valid = stray && c < 2;
        end
        mem_done = 1'b0;
        instr_valid = 1'b0;
        chk($sformatf("%s reg_we_at", tag), reg_at, v.reg_we_at);
        chk($sformatf("%s reg_we_cnt", tag), reg_cnt, (v.reg_we_at >= 0) ? 1 : 0);
        chk($sformatf("%s pc_we_at", tag), pc_at, v.pc_we_at);
        chk($sformatf("%s pc_we_cnt", tag), pc_cnt, 1);
        chk($sformatf("%s pc_src", tag), {30'd0, src_seen}, {30'd0, v.pc_src});
        if (v.reg_we_at >= 0) chk($sformatf("%s wb_sel", tag), {30'd0, wb_seen}, {30'd0, v.wb_sel});
        chk($sformatf("%s ready_at", tag), rdy_at, v.ready_at);
        chk($sformatf("%s mem_cycles", tag), mem_cnt, v.mem_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int pc_cnt, reg_cnt, ill_cnt, rdy_cnt;

        //        instr         z  l  done  alu      as bs     cs imm           ci rd  memop   rwe pwe src    wb     rdy mem
        vecs[0]  = '{32'h002081B3, 0, 0, -1, 4'b0000, 0, 2'b00, 1, 32'h0,        0, 3,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[1]  = '{32'h4020D093, 0, 0, -1, 4'b1101, 0, 2'b01, 1, 32'h402,      1, 1,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[2]  = '{32'h00208463, 1, 0, -1, 4'b0010, 0, 2'b00, 1, 32'h8,        1, 8,  3'b000, -1, 2,  2'b01, 2'b00, 2, 0};
        vecs[3]  = '{32'h00208463, 0, 0, -1, 4'b0010, 0, 2'b00, 1, 32'h8,        1, 8,  3'b000, -1, 2,  2'b00, 2'b00, 2, 0};
        vecs[4]  = '{32'h00209463, 0, 0, -1, 4'b0010, 0, 2'b00, 1, 32'h8,        1, 8,  3'b000, -1, 2,  2'b01, 2'b00, 2, 0};
        vecs[5]  = '{32'h0020C463, 0, 1, -1, 4'b0010, 0, 2'b00, 1, 32'h8,        1, 8,  3'b000, -1, 2,  2'b01, 2'b00, 2, 0};
        vecs[6]  = '{32'h0020F463, 0, 1, -1, 4'b0011, 0, 2'b00, 1, 32'h8,        1, 8,  3'b000, -1, 2,  2'b00, 2'b00, 2, 0};
        vecs[7]  = '{32'h00C0A283, 0, 0, 5,  4'b0000, 0, 2'b01, 1, 32'hC,        1, 5,  3'b010, 7,  7,  2'b00, 2'b01, 7, 4};
        vecs[8]  = '{32'hFE20AE23, 0, 0, 2,  4'b0000, 0, 2'b01, 1, 32'hFFFFFFFC, 1, 28, 3'b010, -1, 3,  2'b00, 2'b00, 3, 1};
        vecs[9]  = '{32'h123453B7, 0, 0, -1, 4'b1111, 0, 2'b01, 1, 32'h12345000, 1, 7,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[10] = '{32'h00001217, 0, 0, -1, 4'b0000, 1, 2'b01, 1, 32'h1000,     1, 4,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[11] = '{32'h010000EF, 0, 0, -1, 4'b0000, 0, 2'b00, 0, 32'h10,       1, 1,  3'b000, 3,  3,  2'b01, 2'b10, 3, 0};
        vecs[12] = '{32'h00008067, 0, 0, -1, 4'b0000, 0, 2'b01, 1, 32'h0,        1, 0,  3'b000, -1, 3,  2'b10, 2'b10, 3, 0};
        vecs[13] = '{32'h407302B3, 0, 0, -1, 4'b1000, 0, 2'b00, 1, 32'h0,        0, 5,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[14] = '{32'hFFF17113, 0, 0, -1, 4'b0111, 0, 2'b01, 1, 32'hFFFFFFFF, 1, 2,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[15] = '{32'h003130B3, 0, 0, -1, 4'b0011, 0, 2'b00, 1, 32'h0,        0, 1,  3'b000, 3,  3,  2'b00, 2'b00, 3, 0};
        vecs[16] = '{32'h00000303, 0, 0, 2,  4'b0000, 0, 2'b01, 1, 32'h0,        1, 6,  3'b000, 4,  4,  2'b00, 2'b01, 4, 1};

        repeat (3) @(negedge clk);
        chk("rst instr_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst strobes", {27'd0, reg_we, pc_we, mem_re, mem_we, illegal}, 32'd0);
        chk("rst aluctr", {28'd0, aluctr}, 32'd0);
        chk("rst imm", imm, 32'd0);
        chk("rst fields", {17'd0, rs1, rs2, rd}, 32'd0);
        chk("rst sels", {24'd0, alu_asrc, alu_bsrc, wb_sel, pc_src, 1'b0}, 32'd0);
        chk("rst memop", {29'd0, memop}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst instr_ready", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i, 1'b0);

        // add with instr_valid and mem_done held high outside FETCH/MEM
        run_vec(vecs[0], 0, 1'b1);

        // all-ones word is undecodable
        pc_cnt = 0; reg_cnt = 0; ill_cnt = 0; rdy_cnt = 0;
        fetch(32'hFFFFFFFF, ok);
        chk("ill fetch_ready", {31'd0, ok}, 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (pc_we) pc_cnt++;
            if (reg_we) reg_cnt++;
            if (illegal) ill_cnt++;
            if (instr_ready) rdy_cnt++;
        end
        chk("ill reg_we_cnt", reg_cnt, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill flag", {31'd0, illegal}, 32'd1);
        chk("ill ready_cnt", rdy_cnt, 0);
        chk("ill pc_we_cnt", pc_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ill flag_cleared", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("ill ready_after_rst", {31'd0, instr_ready}, 32'd1);
`else
        chk("ill flag", ill_cnt, 0);
        chk("ill pc_we_cnt", pc_cnt, 1);
        chk("ill ready", {31'd0, instr_ready}, 32'd1);
`endif

        // reset while a store waits in MEM
        fetch(32'hFE20AE23, ok);
        chk("rstmem fetch_ready", {31'd0, ok}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rstmem mem_we_pending", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmem mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstmem instr_ready", {31'd0, instr_ready}, 32'd0);
        chk("rstmem pc_we", {31'd0, pc_we}, 32'd0);
        rst = 1'b0;
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("rstmem ready_after", {31'd0, instr_ready}, 32'd1);
        chk("rstmem no_late_write", {30'd0, mem_we, pc_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
